// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional odd parity, STOP_BITS stop bits.
// Define SERIAL_FRAME_TX_PARITY_EN to insert the parity bit between data and stop.
module serial_frame_tx #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out,
    output logic              busy,
    output logic              tx_done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_hold;
    logic              r_holdValid;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out;
    logic              r_txDone;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic              r_parity;
`endif
    logic [DATA_W-1:0] w_shiftNext;

    assign w_shiftNext = r_shift >> 1;
    assign in_ready    = ~r_holdValid;
    assign busy        = (r_state != S_IDLE);
    assign out         = r_out;
    assign tx_done     = r_txDone;

    // r_out always carries the value of the state being entered, so the line is purely registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_holdValid <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_out       <= 1'b1;
            r_txDone    <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_txDone <= 1'b0;

            if (in_valid && !r_holdValid) begin
                r_hold      <= in_data;
                r_holdValid <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_out <= 1'b1;
                    if (r_holdValid) begin
                        r_shift     <= r_hold;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        r_parity    <= ~^r_hold;
`endif
                        r_holdValid <= 1'b0;
                        r_state     <= S_START;
                        r_out       <= 1'b0;
                    end
                end

                S_START: begin
                    r_state <= S_DATA;
                    r_cnt   <= '0;
                    r_out   <= r_shift[0];
                end

                S_DATA: begin
                    r_shift <= w_shiftNext;
                    if (r_cnt == LAST_BIT) begin
                        r_cnt <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        r_state <= S_PARITY;
                        r_out   <= r_parity;
`else
                        r_state  <= S_STOP;
                        r_out    <= 1'b1;
                        r_txDone <= (LAST_STOP == '0);
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                        r_out <= w_shiftNext[0];
                    end
                end

`ifdef SERIAL_FRAME_TX_PARITY_EN
                S_PARITY: begin
                    r_state  <= S_STOP;
                    r_cnt    <= '0;
                    r_out    <= 1'b1;
                    r_txDone <= (LAST_STOP == '0);
                end
`endif

                S_STOP: begin
                    if (r_cnt == LAST_STOP) begin
                        r_cnt <= '0;
                        // A waiting word starts on the very next cycle, so frames abut.
                        if (r_holdValid) begin
                            r_shift     <= r_hold;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                            r_parity    <= ~^r_hold;
`endif
                            r_holdValid <= 1'b0;
                            r_state     <= S_START;
                            r_out       <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_out   <= 1'b1;
                        end
                    end else begin
                        r_cnt    <= r_cnt + CNT_ONE;
                        r_out    <= 1'b1;
                        r_txDone <= ((r_cnt + CNT_ONE) == LAST_STOP);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_out   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: queue-based line model, serial receiver model, literal frame checks.
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_LEN = 1 + 8 + PAR + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_valid2;
    logic [7:0] in_data, in_data2;
    logic       in_ready, out, busy, tx_done;
    logic       ready2, out2, busy2, done2;

    int compared   = 0;
    int mismatched = 0;

    bit       lineQ[$];
    bit       modelHoldFull = 1'b0;
    bit [7:0] modelHoldWord = 8'h00;
    bit [7:0] sentQ[$];
    bit [7:0] rxQ[$];
    int       rxPos = 0;
    bit [7:0] rxWord = 8'h00;
    bit       checkOn = 1'b0;
    bit       logOn = 1'b0;
    bit       logOut[$];
    bit       logBusy[$];
    bit       logDone[$];

    serial_frame_tx #(.DATA_W(8), .STOP_BITS(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out(out), .busy(busy), .tx_done(tx_done)
    );

    serial_frame_tx #(.DATA_W(8), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(ready2), .out(out2), .busy(busy2), .tx_done(done2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushFrame(input bit [7:0] w);
        lineQ.push_back(1'b0);
        for (int i = 0; i < 8; i++) lineQ.push_back(w[i]);
        if (PAR != 0) lineQ.push_back(~^w);
        lineQ.push_back(1'b1);
    endtask

    // One clock edge of the model: the bit on the line retires, a held word starts when the line frees up.
    task automatic modelStep();
        bit xfer;
        xfer = in_valid && !modelHoldFull;
        if (lineQ.size() != 0) void'(lineQ.pop_front());
        if (lineQ.size() == 0 && modelHoldFull) begin
            pushFrame(modelHoldWord);
            modelHoldFull = 1'b0;
        end
        if (xfer) begin
            modelHoldFull = 1'b1;
            modelHoldWord = in_data;
            sentQ.push_back(in_data);
        end
    endtask

    always @(posedge reset) begin
        lineQ.delete();
        modelHoldFull = 1'b0;
        rxPos = 0;
    end

    always @(posedge clk) begin
        if (!reset) modelStep();
        #1;
        if (checkOn) begin
            checkOutput("out", 32'(out), 32'((lineQ.size() != 0) ? lineQ[0] : 1'b1));
            checkOutput("busy", 32'(busy), 32'(lineQ.size() != 0));
            checkOutput("tx_done", 32'(tx_done), 32'(lineQ.size() == 1));
            checkOutput("in_ready", 32'(in_ready), 32'(!modelHoldFull));
            if (logOn) begin
                logOut.push_back(out);
                logBusy.push_back(busy);
                logDone.push_back(tx_done);
            end
            if (!reset) begin
                if (rxPos == 0) begin
                    if (out == 1'b0) rxPos = 1;
                end else begin
                    if (rxPos <= 8) rxWord[rxPos-1] = out;
                    if (rxPos == FRAME_LEN - 1) begin
                        rxQ.push_back(rxWord);
                        rxPos = 0;
                    end else begin
                        rxPos++;
                    end
                end
            end
        end
    end

    task automatic clearLog();
        logOut.delete();
        logBusy.delete();
        logDone.delete();
    endtask

    // Gathers the busy cycles of the log and pins their line values and tx_done positions.
    task automatic checkFrameLiteral(input string name, input int expN,
                                     input logic [31:0] expSeq, input logic [31:0] expDone);
        int n;
        logic [31:0] seq;
        logic [31:0] dm;
        n = 0;
        seq = '0;
        dm = '0;
        for (int i = 0; i < logBusy.size(); i++) begin
            if (logBusy[i]) begin
                if (n < 32) begin
                    seq[n] = logOut[i];
                    dm[n]  = logDone[i];
                end
                n++;
            end
        end
        checkOutput({name, "Len"}, 32'(n), 32'(expN));
        checkOutput({name, "Bits"}, seq, expSeq);
        checkOutput({name, "Done"}, dm, expDone);
    endtask

    task automatic applyStimulus(input logic [7:0] w);
        int waitCnt;
        in_valid = 1'b1;
        in_data  = w;
        waitCnt  = 0;
        while (!in_ready && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (waitCnt >= 100) checkOutput("handshakeTimeout", 32'(waitCnt), 32'd0);
        @(negedge clk);
    endtask

    task automatic waitIdle();
        int cnt;
        cnt = 0;
        while ((lineQ.size() != 0 || modelHoldFull) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 200) checkOutput("idleTimeout", 32'(cnt), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout: simulation did not complete");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int seq2n;
        logic [31:0] seq2, dm2;
        int idx;

        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_valid2 = 1'b0;
        in_data2 = 8'h00;
        #1;
        checkOutput("resetOut", 32'(out), 32'd1);
        checkOutput("resetReady", 32'(in_ready), 32'd1);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(tx_done), 32'd0);
        checkOn = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] single frame 0x4B");
        clearLog();
        logOn = 1'b1;
        applyStimulus(8'h4B);
        in_valid = 1'b0;
        repeat (16) @(negedge clk);
        if (PAR != 0) checkFrameLiteral("single", 11, 32'h696, 32'h400);
        else          checkFrameLiteral("single", 10, 32'h296, 32'h200);

`ifdef SERIAL_FRAME_TX_PARITY_EN
        clearLog();
        applyStimulus(8'h03);
        in_valid = 1'b0;
        repeat (16) @(negedge clk);
        checkFrameLiteral("parity03", 11, 32'h606, 32'h400);
        clearLog();
        applyStimulus(8'h07);
        in_valid = 1'b0;
        repeat (16) @(negedge clk);
        checkFrameLiteral("parity07", 11, 32'h40E, 32'h400);
`endif

        $display("[TB] back-to-back 0xA5 0x3C");
        clearLog();
        applyStimulus(8'hA5);
        applyStimulus(8'h3C);
        in_valid = 1'b0;
        repeat (26) @(negedge clk);
        if (PAR == 0) checkFrameLiteral("b2b", 20, 32'h9E34A, 32'h80200);
        logOn = 1'b0;
        waitIdle();

        $display("[TB] backpressure and random traffic");
        sentQ.delete();
        rxQ.delete();
        for (int k = 0; k < 3; k++) applyStimulus(8'($urandom));
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 4)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
            applyStimulus(8'($urandom));
        end
        in_valid = 1'b0;
        waitIdle();
        checkOutput("rxCount", 32'(rxQ.size()), 32'(sentQ.size()));
        checkOutput("sentCount", 32'(sentQ.size()), 32'd43);
        for (int k = 0; k < sentQ.size() && k < rxQ.size(); k++)
            checkOutput("rxWord", 32'(rxQ[k]), 32'(sentQ[k]));

        $display("[TB] two stop bits, byte 0x00");
        checkOutput("stop2Ready", 32'(ready2), 32'd1);
        in_valid2 = 1'b1;
        in_data2  = 8'h00;
        @(negedge clk);
        in_valid2 = 1'b0;
        seq2n = 0;
        seq2 = '0;
        dm2 = '0;
        repeat (18) begin
            @(posedge clk);
            #1;
            if (busy2) begin
                idx = seq2n;
                if (idx < 32) begin
                    seq2[idx] = out2;
                    dm2[idx]  = done2;
                end
                seq2n++;
            end
        end
        checkOutput("stop2Len", 32'(seq2n), 32'(11 + PAR));
        checkOutput("stop2Bits", seq2, (PAR != 0) ? 32'hE00 : 32'h600);
        checkOutput("stop2Done", dm2, (PAR != 0) ? 32'h800 : 32'h400);
        @(negedge clk);

        $display("[TB] reset during data bit 4 of 0xFF with hold full");
        applyStimulus(8'hFF);
        applyStimulus(8'h5A);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checkOutput("preResetBusy", 32'(busy), 32'd1);
        checkOutput("preResetReady", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("midResetOut", 32'(out), 32'd1);
        checkOutput("midResetReady", 32'(in_ready), 32'd1);
        checkOutput("midResetBusy", 32'(busy), 32'd0);
        checkOutput("midResetDone", 32'(tx_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clearLog();
        logOn = 1'b1;
        repeat (20) @(negedge clk);
        checkFrameLiteral("postReset", 0, 32'h0, 32'h0);
        logOn = 1'b0;

        checkOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
